// File: rtl/mmio_gpio_pkg.sv
// Shared definitions for the memory-mapped GPIO block: register offsets and default window.
package io_defs;

    localparam int unsigned BUS_W = 32;

    localparam logic [31:0] GPIO_BASE_ADDR = 32'hFFFF_FC00;

    localparam logic [7:0] GPIO_LED_DATA  = 8'h60;
    localparam logic [7:0] GPIO_LED_BLINK = 8'h64;
    localparam logic [7:0] GPIO_SW_STATE  = 8'h70;
    localparam logic [7:0] GPIO_SW_CHG    = 8'h74;
    localparam logic [7:0] GPIO_IRQ_EN    = 8'h78;

endpackage

// File: rtl/mmio_gpio_if.sv
// CPU-side I/O bus: strobes, address and write data in; registered read data out.
interface mmio_gpio_if;
    import io_defs::*;

    logic             ioRead;
    logic             ioWrite;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
    logic [BUS_W-1:0] rdata;
    logic             rvalid;

    modport master (output ioRead, ioWrite, addr, wdata, input rdata, rvalid);
    modport slave  (input ioRead, ioWrite, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/mmio_gpio_debounce.sv
// Switch debouncer: 2-FF synchroniser, shared sample tick, two-sample agreement.
module sw_debounce #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIV   = 20000
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] change
);
    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;
    logic [CW-1:0]    cnt;
    logic             tick;

    assign tick = (cnt == CW'(DIV - 1));

    // A bit moves only when two consecutive samples agree and differ from the current state.
    assign change = tick ? (~(sync ^ prev) & (sync ^ state)) : '0;

    // Synchroniser, sample divider, previous sample and debounced state.
    always_ff @(posedge clock) begin
        if (!rst) begin
            meta  <= '0;
            sync  <= '0;
            prev  <= '0;
            cnt   <= '0;
            state <= '0;
        end else begin
            meta  <= switches;
            sync  <= meta;
            cnt   <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                prev <= sync;
            end
            state <= state ^ change;
        end
    end
endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: LED register with per-bit blink, debounced switches with sticky change flags.
module mmio_gpio
    import io_defs::*;
#(
    parameter int unsigned SW_WIDTH  = 16,
    parameter int unsigned LED_WIDTH = 24,
    parameter logic [31:0] BASE_ADDR = GPIO_BASE_ADDR,
    parameter int unsigned DEB_DIV   = 20000,
    parameter int unsigned BLINK_DIV = 5000000
) (
    input  logic                 clock,
    input  logic                 rst,
    mmio_gpio_if.slave           bus,
    input  logic [SW_WIDTH-1:0]  switches,
    output logic [LED_WIDTH-1:0] ledout,
    output logic                 irq
);
    localparam int unsigned BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [LED_WIDTH-1:0] led_data;
    logic [LED_WIDTH-1:0] led_blink;
    logic [SW_WIDTH-1:0]  sw_state;
    logic [SW_WIDTH-1:0]  sw_change;
    logic [SW_WIDTH-1:0]  sw_chg;
    logic [SW_WIDTH-1:0]  irq_en;
    logic [SW_WIDTH-1:0]  clr_mask;
    logic [BW-1:0]        bcnt;
    logic                 phase;
    logic                 hit;
    logic                 rd_hit;
    logic                 wr_hit;
    logic [7:0]           off;
    logic [BUS_W-1:0]     rd_mux;
    logic                 unused_bits;

    sw_debounce #(
        .WIDTH (SW_WIDTH),
        .DIV   (DEB_DIV)
    ) u_deb (
        .clock    (clock),
        .rst      (rst),
        .switches (switches),
        .state    (sw_state),
        .change   (sw_change)
    );

    assign hit      = (bus.addr[31:8] == BASE_ADDR[31:8]);
    assign off      = bus.addr[7:0];
    assign rd_hit   = bus.ioRead & hit;
    assign wr_hit   = bus.ioWrite & hit;
    assign clr_mask = (wr_hit && off == GPIO_SW_CHG) ? bus.wdata[SW_WIDTH-1:0] : '0;

    // Register fields narrower than the bus leave upper write-data bits unused.
    assign unused_bits = ^bus.wdata;

    // Read mux over pre-write register values; unmapped offsets read zero.
    always_comb begin
        rd_mux = '0;
        case (off)
            GPIO_LED_DATA:  rd_mux = BUS_W'(led_data);
            GPIO_LED_BLINK: rd_mux = BUS_W'(led_blink);
            GPIO_SW_STATE:  rd_mux = BUS_W'(sw_state);
            GPIO_SW_CHG:    rd_mux = BUS_W'(sw_chg);
            GPIO_IRQ_EN:    rd_mux = BUS_W'(irq_en);
            default:        rd_mux = '0;
        endcase
    end

    // Register file, sticky change flags (set beats clear) and registered read response.
    always_ff @(posedge clock) begin
        if (!rst) begin
            led_data   <= '0;
            led_blink  <= '0;
            irq_en     <= '0;
            sw_chg     <= '0;
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
        end else begin
            bus.rvalid <= rd_hit;
            if (rd_hit) begin
                bus.rdata <= rd_mux;
            end
            if (wr_hit) begin
                case (off)
                    GPIO_LED_DATA:  led_data  <= bus.wdata[LED_WIDTH-1:0];
                    GPIO_LED_BLINK: led_blink <= bus.wdata[LED_WIDTH-1:0];
                    GPIO_IRQ_EN:    irq_en    <= bus.wdata[SW_WIDTH-1:0];
                    default:        ;
                endcase
            end
            sw_chg <= (sw_chg & ~clr_mask) | sw_change;
        end
    end

    // Free-running blink divider; phase flips on the wrap cycle.
    always_ff @(posedge clock) begin
        if (!rst) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (bcnt == BW'(BLINK_DIV - 1)) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt  <= bcnt + BW'(1);
        end
    end

    assign ledout = led_data ^ (led_blink & {LED_WIDTH{phase}});
    assign irq    = |(sw_chg & irq_en);
endmodule

// File: tb/tb_mmio_gpio.sv
// Scoreboard bench for mmio_gpio with a register-level reference model.
module tb_mmio_gpio;
    import io_defs::*;

    localparam int unsigned BLK = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic [23:0] ledout;
    logic        irq;

    mmio_gpio_if bus();

    mmio_gpio #(
        .SW_WIDTH  (16),
        .LED_WIDTH (24),
        .BASE_ADDR (GPIO_BASE_ADDR),
        .DEB_DIV   (4),
        .BLINK_DIV (8)
    ) dut (
        .clock    (clk),
        .rst      (rst),
        .bus      (bus),
        .switches (sw),
        .ledout   (ledout),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_led, m_blink, m_sw, m_chg, m_en, m_rdata;
    logic [31:0] exp_q[$];
    int          ncyc = 0;
    bit          settling = 1'b0;
    bit          mon_en = 1'b0;
    logic [31:0] base_w = GPIO_BASE_ADDR;
    logic [7:0]  offs[7] = '{8'h60, 8'h64, 8'h70, 8'h74, 8'h78, 8'h6C, 8'h00};

    // Clock edges seen out of reset; blink phase is derived from this.
    always @(posedge clk) ncyc <= rst ? ncyc + 1 : 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_led();
        bit ph;
        ph = ((ncyc / BLK) % 2) == 1;
        return m_led ^ (ph ? m_blink : 32'h0);
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] o);
        case (o)
            8'h60:   return m_led;
            8'h64:   return m_blink;
            8'h70:   return m_sw;
            8'h74:   return m_chg;
            8'h78:   return m_en;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [7:0] o, input logic [31:0] d);
        case (o)
            8'h60:   m_led   = d & 32'h00FF_FFFF;
            8'h64:   m_blink = d & 32'h00FF_FFFF;
            8'h74:   m_chg   = m_chg & ~d;
            8'h78:   m_en    = d & 32'h0000_FFFF;
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_led = 0; m_blink = 0; m_sw = 0; m_chg = 0; m_en = 0; m_rdata = 0;
        exp_q.delete();
    endtask

    // Monitor: pops expected read data on rvalid, checks LED and IRQ outputs every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.rvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'(bus.rvalid), 32'h0);
                end else begin
                    m_rdata = exp_q.pop_front();
                    chk("rdata", bus.rdata, m_rdata);
                end
            end else begin
                chk("rvalid_idle", 32'(bus.rvalid), 32'h0);
                chk("rdata_hold", bus.rdata, m_rdata);
            end
            chk("ledout", 32'(ledout), model_led());
            if (!settling) chk("irq", 32'(irq), 32'(|(m_chg & m_en)));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus cycle; expected read data is captured before the write lands.
    task automatic op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        bit hit;
        hit = (a[31:8] == base_w[31:8]);
        bus.ioRead  = rd;
        bus.ioWrite = wr;
        bus.addr    = a;
        bus.wdata   = d;
        if (rd && hit) exp_q.push_back(model_read(a[7:0]));
        @(posedge clk);
        #1;
        bus.ioRead  = 1'b0;
        bus.ioWrite = 1'b0;
        if (wr && hit) model_write(a[7:0], d);
    endtask

    // Hold a new switch value long enough to be accepted, then update the model.
    task automatic apply_sw(input logic [15:0] v, input int hold);
        settling = 1'b1;
        sw = v;
        idle(hold);
        m_chg = m_chg | (m_sw ^ 32'(v));
        m_sw  = 32'(v);
        settling = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        sw = '0;
        bus.ioRead = 1'b0;
        bus.ioWrite = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        model_reset();
        idle(3);
        rst = 1'b1;
        mon_en = 1'b1;

        // Idle after reset
        idle(20);
        chk("reset_ledout", 32'(ledout), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_rvalid", 32'(bus.rvalid), 32'h0);
        op(1, 0, base_w | 32'h70, 0);
        idle(2);

        // LED data write and readback
        op(0, 1, base_w | 32'h60, 32'h00AB_CDEF);
        chk("ledout_write", 32'(ledout), 32'h00AB_CDEF);
        op(1, 0, base_w | 32'h60, 0);

        // Blink on bit 0
        op(0, 1, base_w | 32'h60, 0);
        op(0, 1, base_w | 32'h64, 32'h1);
        idle(24);
        op(0, 1, base_w | 32'h64, 0);

        // Switch pattern 0x5, interrupt and W1C
        op(0, 1, base_w | 32'h78, 32'h1);
        apply_sw(16'h0005, 10);
        op(1, 0, base_w | 32'h70, 0);
        op(1, 0, base_w | 32'h74, 0);
        chk("irq_set", 32'(irq), 32'h1);
        op(0, 1, base_w | 32'h74, 32'h1);
        chk("irq_cleared", 32'(irq), 32'h0);
        op(1, 0, base_w | 32'h74, 0);

        // One-cycle glitch on switch 1 must be rejected
        sw = 16'h0007;
        idle(1);
        sw = 16'h0005;
        idle(12);
        op(1, 0, base_w | 32'h70, 0);
        op(1, 0, base_w | 32'h74, 0);

        // Randomised traffic
        for (int it = 0; it < 25; it++) begin
            logic [15:0] v;
            v = ($urandom_range(0, 3) == 0) ? m_sw[15:0] : 16'($urandom);
            apply_sw(v, 12);
            for (int k = 0; k < 6; k++) begin
                logic [31:0] a, d;
                int kind;
                a = base_w | 32'(offs[$urandom_range(0, 6)]);
                d = $urandom;
                kind = $urandom_range(0, 5);
                case (kind)
                    0: op(0, 1, a, d);
                    1: op(1, 0, a, d);
                    2: op(1, 1, a, d);
                    3: op(0, 1, {8'h10, a[23:0]}, d);
                    4: op(1, 0, {8'h10, a[23:0]}, d);
                    default: idle(1);
                endcase
            end
        end

        // Reset on a read cycle with LED data set
        op(0, 1, base_w | 32'h60, 32'h0012_3456);
        sw = '0;
        rst = 1'b0;
        bus.ioRead = 1'b1;
        bus.addr = base_w | 32'h60;
        @(posedge clk);
        #1;
        bus.ioRead = 1'b0;
        rst = 1'b1;
        model_reset();
        chk("rst_ledout", 32'(ledout), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        idle(3);
        op(1, 0, base_w | 32'h60, 0);
        op(0, 1, base_w | 32'h64, 32'h00F0_000F);
        op(1, 0, base_w | 32'h64, 0);
        idle(4);
        chk("pending_reads", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
